// File: rtl/bus_rr_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// bus_arb_pkg
// Shared types and helpers for the bus_rr_arbiter block.
//   arb_state_t  : sequencer state (IDLE -> POP -> ROUTE -> DELIVER)
//   BROADCAST_ID : default ID value that fans a packet out to every terminal
//                  except its source
//   onehot16     : index -> one-hot (terminal count is at most 16)
//   id_extract   : pulls the ID field out of the top id_w bits of a packet
// ---------------------------------------------------------------------------
package bus_arb_pkg;

    typedef enum logic [1:0] {IDLE, POP, ROUTE, DELIVER} arb_state_t;

    localparam logic [7:0] BROADCAST_ID = 8'hFF;

    function automatic logic [15:0] onehot16(input logic [3:0] idx);
        return 16'd1 << idx;
    endfunction

    // Packet is passed zero-extended to 64 bits so one helper serves any width.
    function automatic logic [31:0] id_extract(input logic [63:0] pkt,
                                               input int          width,
                                               input int          id_w);
        logic [63:0] s;
        s = (pkt >> (width - id_w)) & ((64'd1 << id_w) - 64'd1);
        return 32'(s);
    endfunction

endpackage

// File: rtl/bus_rr_arbiter_if.sv
// ---------------------------------------------------------------------------
// bus_rr_arbiter_if
// Terminal FIFO side of the shared data bus.
//   pndng    : input FIFO i not empty
//   D_pop    : head word of input FIFO i (first-word fall-through), slice i
//   pop      : one-cycle pop strobe to input FIFO i
//   full_out : output FIFO i full
//   push     : one-cycle push strobe to output FIFO i
//   D_push   : shared bus data, valid while any push bit is set
// master = arbiter side, slave = FIFO/environment side.
// ---------------------------------------------------------------------------
interface bus_rr_arbiter_if #(
    parameter int drivers = 4,
    parameter int width   = 16
);
    logic [drivers-1:0]       pndng;
    logic [drivers*width-1:0] D_pop;
    logic [drivers-1:0]       pop;
    logic [drivers-1:0]       full_out;
    logic [drivers-1:0]       push;
    logic [width-1:0]         D_push;

    modport master (input pndng, D_pop, full_out, output pop, push, D_push);
    modport slave  (output pndng, D_pop, full_out, input pop, push, D_push);
endinterface

// File: rtl/bus_rr_arbiter_rr_pick.sv
// ---------------------------------------------------------------------------
// rr_pick
// Combinational round-robin search: returns the first requester found when
// scanning upward from i_base+1 (mod drivers), wrapping through i_base last.
//   i_req  : request vector
//   i_base : index of the previous winner
//   o_idx  : selected index (0 when o_vld is low)
//   o_vld  : any request present
// ---------------------------------------------------------------------------
module rr_pick #(
    parameter int drivers = 4
) (
    input  logic [drivers-1:0]         i_req,
    input  logic [$clog2(drivers)-1:0] i_base,
    output logic [$clog2(drivers)-1:0] o_idx,
    output logic                       o_vld
);
    localparam int IW = $clog2(drivers);

    logic [IW-1:0] w_cand;

    // Walk from the farthest candidate to the nearest so the nearest one
    // after the base is the final assignment.
    always_comb begin
        o_vld  = |i_req;
        o_idx  = '0;
        w_cand = '0;
        for (int k = drivers; k >= 1; k--) begin
            w_cand = IW'((int'(i_base) + k) % drivers);
            if (i_req[w_cand]) o_idx = w_cand;
        end
    end
endmodule

// File: rtl/bus_rr_arbiter.sv
// ---------------------------------------------------------------------------
// bus_rr_arbiter
// Round-robin sequencer for the shared bus between per-terminal input FIFOs
// and output FIFOs. One packet {ID, payload} at a time: pop the winning
// source, decode the ID, then push into the destination FIFO(s).
//   clk, reset : clock (rising edge), asynchronous active-high reset
//   bus        : FIFO-side bundle (pndng, D_pop, pop, full_out, push, D_push)
//   grant_id   : index of the current/last granted source
//   busy       : sequencer not idle
//   drop_err   : one-cycle pulse when a packet with an unknown ID is dropped
// Optional: define BUS_ARB_STATS_EN to add grant_cnt (per-source saturating
// pop counters, 16 bits each) and stall_cnt (saturating count of DELIVER
// cycles blocked by full_out).
// A reset during a transfer discards a packet that was already popped.
// ---------------------------------------------------------------------------
module bus_rr_arbiter
    import bus_arb_pkg::*;
#(
    parameter int               width     = 16,
    parameter int               drivers   = 4,
    parameter int               id_w      = 8,
    parameter logic [id_w-1:0]  broadcast = id_w'(BROADCAST_ID)
) (
    input  logic                       clk,
    input  logic                       reset,
    bus_rr_arbiter_if.master           bus,
    output logic [$clog2(drivers)-1:0] grant_id,
    output logic                       busy,
    output logic                       drop_err
`ifdef BUS_ARB_STATS_EN
    ,
    output logic [drivers*16-1:0]      grant_cnt,
    output logic [15:0]                stall_cnt
`endif
);
    localparam int          IW    = $clog2(drivers);
    localparam logic [31:0] NDRV  = 32'(drivers);
    localparam logic [31:0] BCAST = 32'(broadcast);

    arb_state_t         r_state;
    logic [width-1:0]   r_pkt;
    logic [drivers-1:0] r_dest;

    logic [IW-1:0]      w_pick_idx;
    logic               w_pick_vld;
    logic [drivers-1:0] w_pick_oh;
    logic [drivers-1:0] w_grant_oh;
    logic [drivers-1:0] w_id_oh;
    logic [31:0]        w_id;
    logic [width-1:0]   w_head;
    logic               w_blocked;

    rr_pick #(.drivers(drivers)) u_pick (
        .i_req  (bus.pndng),
        .i_base (grant_id),
        .o_idx  (w_pick_idx),
        .o_vld  (w_pick_vld)
    );

    always_comb begin
        w_pick_oh  = drivers'(onehot16(4'(w_pick_idx)));
        w_grant_oh = drivers'(onehot16(4'(grant_id)));
        w_id       = id_extract(64'(r_pkt), width, id_w);
        w_id_oh    = drivers'(onehot16(w_id[3:0]));
        w_head     = bus.D_pop[int'(grant_id)*width +: width];
        // Any targeted FIFO full holds the whole transfer, so a broadcast
        // never lands partially.
        w_blocked  = |(r_dest & bus.full_out);
    end

    assign busy = (r_state != IDLE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= IDLE;
            r_pkt      <= '0;
            r_dest     <= '0;
            grant_id   <= IW'(drivers - 1);
            drop_err   <= 1'b0;
            bus.pop    <= '0;
            bus.push   <= '0;
            bus.D_push <= '0;
        end else begin
            bus.pop  <= '0;
            bus.push <= '0;
            drop_err <= 1'b0;
            case (r_state)
                IDLE: if (w_pick_vld) begin
                    grant_id <= w_pick_idx;
                    bus.pop  <= w_pick_oh;
                    r_state  <= POP;
                end
                // FIFO is first-word fall-through: head is valid while pop is high.
                POP: begin
                    r_pkt   <= w_head;
                    r_state <= ROUTE;
                end
                ROUTE: begin
                    if (w_id < NDRV) begin
                        r_dest  <= w_id_oh;
                        r_state <= DELIVER;
                    end else if (w_id == BCAST) begin
                        r_dest  <= ~w_grant_oh;
                        r_state <= DELIVER;
                    end else begin
                        drop_err <= 1'b1;
                        r_state  <= IDLE;
                    end
                end
                DELIVER: if (!w_blocked) begin
                    bus.push   <= r_dest;
                    bus.D_push <= r_pkt;
                    r_state    <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

`ifdef BUS_ARB_STATS_EN
    logic [drivers-1:0][15:0] r_gcnt;
    logic [15:0]              r_stall;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_gcnt  <= '0;
            r_stall <= '0;
        end else begin
            if (r_state == POP && r_gcnt[grant_id] != 16'hFFFF)
                r_gcnt[grant_id] <= r_gcnt[grant_id] + 16'd1;
            if (r_state == DELIVER && w_blocked && r_stall != 16'hFFFF)
                r_stall <= r_stall + 16'd1;
        end
    end

    assign grant_cnt = r_gcnt;
    assign stall_cnt = r_stall;
`endif

endmodule
